io_unit: RTL and testbench

- Responder for the core's data_in/data_out I/O instructions. The decoder raises those flags as one-cycle pulses; this block services them.
- Outbound: buffers 32-bit words and serializes them little-endian into bytes for the UART transmitter.
- Inbound: assembles received bytes into 32-bit words and returns them on core request.
- Sits between the core's EXEC/WRITE datapath and the uart_tx/uart_rx byte interfaces.

---
 rtl/io_unit.sv | 245 ++++++++++++++++++++++++
 tb/tb_io_unit.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_unit.sv
// io_unit: services the core's data_out / data_in I/O instructions.
// Outbound words are queued and serialized little-endian onto the uart_tx
// byte interface; inbound bytes from uart_rx are assembled into words and
// queued until the core asks for one.
module io_unit #(
  parameter int OUT_DEPTH = 16,
  parameter int IN_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        out_req,
  input  logic [31:0] out_data,
  output logic        out_full,
  input  logic        in_req,
  output logic [31:0] in_data,
  output logic        in_valid,
  output logic        in_busy,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic        out_overflow,
  output logic        in_overflow
);

  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int IAW = $clog2(IN_DEPTH);
  localparam logic [OAW:0] OUT_PTR_ONE = {{OAW{1'b0}}, 1'b1};
  localparam logic [IAW:0] IN_PTR_ONE  = {{IAW{1'b0}}, 1'b1};

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
  typedef enum logic {IN_IDLE, IN_WAIT} in_state_t;

  // ---------------------------------------------------------------------------
  // Outbound word FIFO
  // ---------------------------------------------------------------------------
  logic [31:0]  r_out_mem [OUT_DEPTH];
  logic [OAW:0] r_out_wr, r_out_rd;
  logic [OAW:0] w_out_wr_nxt, w_out_rd_nxt;
  logic         r_out_full, r_out_overflow;
  logic         w_out_push, w_out_pop, w_out_empty;

  assign w_out_push   = out_req && !r_out_full;
  assign w_out_empty  = (r_out_wr == r_out_rd);
  assign w_out_wr_nxt = w_out_push ? r_out_wr + OUT_PTR_ONE : r_out_wr;
  assign w_out_rd_nxt = w_out_pop  ? r_out_rd + OUT_PTR_ONE : r_out_rd;

  // Outbound storage write.
  // NOTE: FIFO storage has no reset; the pointers alone define what is valid,
  // and leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_out_push) r_out_mem[r_out_wr[OAW-1:0]] <= out_data;
  end

  // Outbound pointers, registered full flag (post-edge count) and sticky overflow.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_wr       <= '0;
      r_out_rd       <= '0;
      r_out_full     <= 1'b0;
      r_out_overflow <= 1'b0;
    end else begin
      r_out_wr       <= w_out_wr_nxt;
      r_out_rd       <= w_out_rd_nxt;
      r_out_full     <= (w_out_wr_nxt[OAW] != w_out_rd_nxt[OAW]) &&
                        (w_out_wr_nxt[OAW-1:0] == w_out_rd_nxt[OAW-1:0]);
      r_out_overflow <= r_out_overflow | (out_req && r_out_full);
    end
  end

  assign out_full     = r_out_full;
  assign out_overflow = r_out_overflow;

  // ---------------------------------------------------------------------------
  // Serializer FSM
  // ---------------------------------------------------------------------------
  tx_state_t   r_tx_state, w_tx_state_nxt;
  logic [1:0]  r_idx, w_idx_nxt;
  logic [31:0] r_shift;
  logic        w_load;

  // Next-state logic: pop a word when idle, or chain straight into the next
  // word after the last byte is accepted.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_idx_nxt      = r_idx;
    w_out_pop      = 1'b0;
    w_load         = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (!w_out_empty) begin
          w_out_pop      = 1'b1;
          w_load         = 1'b1;
          w_idx_nxt      = 2'd0;
          w_tx_state_nxt = TX_SEND;
        end
      end
      TX_SEND: begin
        if (tx_ready) begin
          if (r_idx != 2'd3) begin
            w_idx_nxt = r_idx + 2'd1;
          end else if (!w_out_empty) begin
            w_out_pop = 1'b1;
            w_load    = 1'b1;
            w_idx_nxt = 2'd0;
          end else begin
            w_tx_state_nxt = TX_IDLE;
          end
        end
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
  end

  // Serializer state, byte index and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_idx      <= 2'd0;
      r_shift    <= '0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_idx      <= w_idx_nxt;
      if (w_load) r_shift <= r_out_mem[r_out_rd[OAW-1:0]];
    end
  end

  // Byte select; tx_valid follows the state register so reset drops it at once.
  always_comb begin
    tx_byte = 8'h00;
    if (r_tx_state == TX_SEND) begin
      case (r_idx)
        2'd0:    tx_byte = r_shift[7:0];
        2'd1:    tx_byte = r_shift[15:8];
        2'd2:    tx_byte = r_shift[23:16];
        default: tx_byte = r_shift[31:24];
      endcase
    end
  end

  assign tx_valid = (r_tx_state == TX_SEND);

  // ---------------------------------------------------------------------------
  // Byte assembler and inbound word FIFO
  // ---------------------------------------------------------------------------
  logic [31:0]  r_in_mem [IN_DEPTH];
  logic [IAW:0] r_in_wr, r_in_rd;
  logic [1:0]   r_cnt;
  logic [23:0]  r_asm;
  logic         r_in_overflow;
  logic         w_in_empty, w_in_full, w_word_done, w_in_push, w_in_pop;
  logic [31:0]  w_word;

  assign w_in_empty  = (r_in_wr == r_in_rd);
  assign w_in_full   = (r_in_wr[IAW] != r_in_rd[IAW]) &&
                       (r_in_wr[IAW-1:0] == r_in_rd[IAW-1:0]);
  assign w_word_done = rx_valid && (r_cnt == 2'd3);
  assign w_in_push   = w_word_done && !w_in_full;
  assign w_word      = {rx_byte, r_asm};

  // Inbound storage write.
  always_ff @(posedge clk) begin
    if (w_in_push) r_in_mem[r_in_wr[IAW-1:0]] <= w_word;
  end

  // Byte position counter, partial word, inbound pointers and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= 2'd0;
      r_asm         <= '0;
      r_in_wr       <= '0;
      r_in_rd       <= '0;
      r_in_overflow <= 1'b0;
    end else begin
      if (rx_valid) begin
        r_cnt <= r_cnt + 2'd1;
        case (r_cnt)
          2'd0:    r_asm[7:0]   <= rx_byte;
          2'd1:    r_asm[15:8]  <= rx_byte;
          2'd2:    r_asm[23:16] <= rx_byte;
          default: ;
        endcase
      end
      if (w_in_push) r_in_wr <= r_in_wr + IN_PTR_ONE;
      if (w_in_pop)  r_in_rd <= r_in_rd + IN_PTR_ONE;
      r_in_overflow <= r_in_overflow | (w_word_done && w_in_full);
    end
  end

  assign in_overflow = r_in_overflow;

  // ---------------------------------------------------------------------------
  // Reader FSM
  // ---------------------------------------------------------------------------
  in_state_t   r_in_state, w_in_state_nxt;
  logic [31:0] r_in_data;
  logic        r_in_valid, r_in_busy;

  // Next-state logic: serve a request immediately if a word is queued,
  // otherwise wait (stalling the core) until one arrives.
  always_comb begin
    w_in_state_nxt = r_in_state;
    w_in_pop       = 1'b0;
    case (r_in_state)
      IN_IDLE: begin
        if (in_req) begin
          if (!w_in_empty) w_in_pop = 1'b1;
          else             w_in_state_nxt = IN_WAIT;
        end
      end
      IN_WAIT: begin
        if (!w_in_empty) begin
          w_in_pop       = 1'b1;
          w_in_state_nxt = IN_IDLE;
        end
      end
      default: w_in_state_nxt = IN_IDLE;
    endcase
  end

  // Reader state and registered core-facing outputs; in_data holds after the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_state <= IN_IDLE;
      r_in_data  <= '0;
      r_in_valid <= 1'b0;
      r_in_busy  <= 1'b0;
    end else begin
      r_in_state <= w_in_state_nxt;
      r_in_valid <= w_in_pop;
      r_in_busy  <= (w_in_state_nxt == IN_WAIT);
      if (w_in_pop) r_in_data <= r_in_mem[r_in_rd[IAW-1:0]];
    end
  end

  assign in_data  = r_in_data;
  assign in_valid = r_in_valid;
  assign in_busy  = r_in_busy;

endmodule

// File: tb/tb_io_unit.sv
// Testbench for io_unit: scenario tasks with inline checks, plus a scoreboard
// monitor comparing every accepted tx byte and every returned input word
// against queues filled when stimulus is driven.
module tb_io_unit;

  localparam int OUT_DEPTH = 16;
  localparam int IN_DEPTH  = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        out_req = 1'b0;
  logic [31:0] out_data = '0;
  logic        out_full;
  logic        in_req = 1'b0;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_busy;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        rx_valid = 1'b0;
  logic        out_overflow;
  logic        in_overflow;

  io_unit #(.OUT_DEPTH(OUT_DEPTH), .IN_DEPTH(IN_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .out_req(out_req), .out_data(out_data), .out_full(out_full),
    .in_req(in_req), .in_data(in_data), .in_valid(in_valid), .in_busy(in_busy),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_byte(rx_byte), .rx_valid(rx_valid),
    .out_overflow(out_overflow), .in_overflow(in_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tx_seen = 0;
  logic [7:0]  tx_q[$];
  logic [31:0] in_q[$];

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_valid && tx_ready) begin
        tx_seen++;
        checks++;
        if (tx_q.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected got %02h required none", tx_byte);
        end else begin
          logic [7:0] exp_b;
          exp_b = tx_q.pop_front();
          if (tx_byte !== exp_b) begin
            errors++;
            $display("FAIL tx_byte got %02h required %02h", tx_byte, exp_b);
          end
        end
      end
      if (in_valid) begin
        checks++;
        if (in_q.size() == 0) begin
          errors++;
          $display("FAIL in_unexpected got %08h required none", in_data);
        end else begin
          logic [31:0] exp_w;
          exp_w = in_q.pop_front();
          if (in_data !== exp_w) begin
            errors++;
            $display("FAIL in_data got %08h required %08h", in_data, exp_w);
          end
        end
      end
    end
  end

  // Advance to just after the next rising edge (input drive phase).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_out(input logic [31:0] w, input bit accepted);
    out_req  = 1'b1;
    out_data = w;
    if (accepted) begin
      tx_q.push_back(w[7:0]);   tx_q.push_back(w[15:8]);
      tx_q.push_back(w[23:16]); tx_q.push_back(w[31:24]);
    end
    step();
    out_req = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_rx_word(input logic [31:0] w);
    send_rx(w[7:0]);   send_rx(w[15:8]);
    send_rx(w[23:16]); send_rx(w[31:24]);
  endtask

  task automatic expect_bit(input string name, input logic got, input logic req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %b required %b", name, got, req);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    expect_bit("rst_tx_valid", tx_valid, 1'b0);
    expect_bit("rst_in_valid", in_valid, 1'b0);
    expect_bit("rst_in_busy", in_busy, 1'b0);
    expect_bit("rst_out_full", out_full, 1'b0);
    expect_bit("rst_out_overflow", out_overflow, 1'b0);
    expect_bit("rst_in_overflow", in_overflow, 1'b0);
    checks++;
    if (tx_byte !== 8'h00 || in_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_data got tx_byte=%02h in_data=%08h required 00/00000000", tx_byte, in_data);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single_out();
    int lat = 0;
    int n = 1;
    step();
    tx_ready = 1'b1;
    push_out(32'h44332211, 1'b1);
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (tx_valid) break;
    end
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL single_latency got %0d required 2", lat);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (tx_valid) n++;
      else break;
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL single_run_length got %0d required 4", n);
    end
    expect_bit("single_queue_drained", tx_q.size() == 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_byte = '0;
    step();
    tx_ready = 1'b0;
    push_out(32'hDEADBEEF, 1'b1);
    push_out(32'h01020304, 1'b1);
    for (int cyc = 0; cyc < 60 && acc < 8; cyc++) begin
      tx_ready = (cyc % 2 == 0);
      @(negedge clk);
      checks++;
      if (!tx_valid) begin
        errors++;
        $display("FAIL bp_bubble got tx_valid=0 required 1 at cycle %0d", cyc);
      end
      if (prev_stall) begin
        checks++;
        if (tx_byte !== prev_byte) begin
          errors++;
          $display("FAIL bp_stable got %02h required %02h", tx_byte, prev_byte);
        end
      end
      if (tx_valid && tx_ready) acc++;
      prev_stall = tx_valid && !tx_ready;
      prev_byte  = tx_byte;
      step();
    end
    checks++;
    if (acc != 8) begin
      errors++;
      $display("FAIL bp_accepted got %0d required 8", acc);
    end
    @(negedge clk);
    expect_bit("bp_idle_after", tx_valid, 1'b0);
    expect_bit("bp_queue_drained", tx_q.size() == 0, 1'b1);
    tx_ready = 1'b1;
  endtask

  task automatic test_full();
    int base;
    int waited = 0;
    step();
    tx_ready = 1'b0;
    // Park one word in the serializer so the FIFO itself can fill up.
    push_out(32'hC0C1C2C3, 1'b1);
    step();
    for (int i = 0; i <= OUT_DEPTH; i++) begin
      push_out(32'h1000_0000 + 32'(i), i < OUT_DEPTH);
      if (i < OUT_DEPTH - 1) expect_bit("full_early", out_full, 1'b0);
      else                   expect_bit("full_set", out_full, 1'b1);
    end
    expect_bit("full_overflow", out_overflow, 1'b1);
    base = tx_seen;
    tx_ready = 1'b1;
    while (tx_q.size() != 0 && waited < 400) begin
      step();
      waited++;
    end
    repeat (5) step();
    checks++;
    if (tx_seen - base != 4 * (OUT_DEPTH + 1)) begin
      errors++;
      $display("FAIL full_bytes got %0d required %0d", tx_seen - base, 4 * (OUT_DEPTH + 1));
    end
    expect_bit("full_cleared", out_full, 1'b0);
    expect_bit("full_tx_idle", tx_valid, 1'b0);
  endtask

  task automatic test_input_ready();
    step();
    in_q.push_back(32'h12345678);
    send_rx(8'h78); send_rx(8'h56); send_rx(8'h34); send_rx(8'h12);
    in_req = 1'b1;
    @(negedge clk);
    expect_bit("ready_busy_req", in_busy, 1'b0);
    expect_bit("ready_valid_early", in_valid, 1'b0);
    step();
    in_req = 1'b0;
    @(negedge clk);
    expect_bit("ready_valid", in_valid, 1'b1);
    expect_bit("ready_busy", in_busy, 1'b0);
    step();
    @(negedge clk);
    expect_bit("ready_pulse_end", in_valid, 1'b0);
    checks++;
    if (in_data !== 32'h12345678) begin
      errors++;
      $display("FAIL ready_hold got %08h required 12345678", in_data);
    end
  endtask

  task automatic test_input_wait();
    step();
    in_req = 1'b1;
    step();
    in_req = 1'b0;
    @(negedge clk);
    expect_bit("wait_busy_set", in_busy, 1'b1);
    step();
    in_req = 1'b1;               // ignored while already waiting
    step();
    in_req = 1'b0;
    in_q.push_back(32'hDDCCBBAA);
    send_rx(8'hAA); send_rx(8'hBB); send_rx(8'hCC);
    rx_valid = 1'b1;
    rx_byte  = 8'hDD;
    step();
    rx_valid = 1'b0;
    @(negedge clk);
    expect_bit("wait_valid_k1", in_valid, 1'b0);
    expect_bit("wait_busy_k1", in_busy, 1'b1);
    step();
    @(negedge clk);
    expect_bit("wait_valid_k2", in_valid, 1'b1);
    expect_bit("wait_busy_k2", in_busy, 1'b0);
    step();
    @(negedge clk);
    expect_bit("wait_no_second", in_valid, 1'b0);
    expect_bit("wait_idle_busy", in_busy, 1'b0);
  endtask

  task automatic test_in_overflow();
    int waited = 0;
    step();
    for (int w = 0; w <= IN_DEPTH; w++) begin
      if (w < IN_DEPTH) in_q.push_back(32'hA500_0000 | 32'(w));
      send_rx_word(32'hA500_0000 | 32'(w));
    end
    expect_bit("in_overflow_set", in_overflow, 1'b1);
    for (int r = 0; r < IN_DEPTH; r++) begin
      in_req = 1'b1;
      step();
      in_req = 1'b0;
      step();
    end
    while (in_q.size() != 0 && waited < 20) begin
      step();
      waited++;
    end
    expect_bit("in_drained", in_q.size() == 0, 1'b1);
    expect_bit("in_drain_busy", in_busy, 1'b0);
  endtask

  task automatic test_reset_midop();
    int waited = 0;
    bit got = 1'b0;
    step();
    send_rx(8'hEE); send_rx(8'hFF);
    tx_ready = 1'b0;
    push_out(32'h55667788, 1'b1);
    while (!tx_valid && waited < 5) begin
      step();
      waited++;
    end
    tx_ready = 1'b1;
    step();                      // byte 0x88 accepted, idx now 1
    tx_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    expect_bit("midop_tx_async_drop", tx_valid, 1'b0);
    expect_bit("midop_out_overflow_clr", out_overflow, 1'b0);
    expect_bit("midop_in_overflow_clr", in_overflow, 1'b0);
    tx_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    in_q.push_back(32'h04030201);
    send_rx(8'h01); send_rx(8'h02); send_rx(8'h03); send_rx(8'h04);
    in_req = 1'b1;
    step();
    in_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (in_valid) begin
        got = 1'b1;
        break;
      end
    end
    expect_bit("midop_word_returned", got, 1'b1);
    expect_bit("midop_tx_quiet", tx_valid, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_out();
    test_back_to_back();
    test_full();
    test_input_ready();
    test_input_wait();
    test_in_overflow();
    test_reset_midop();
    repeat (3) step();
    expect_bit("final_tx_queue_empty", tx_q.size() == 0, 1'b1);
    expect_bit("final_in_queue_empty", in_q.size() == 0, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
